alu_arbiter: RTL and testbench

Shares one combinational ALU (ALU, ALUop.vh encodings) between two requesters, e.g. the pipeline's side path and a CSR/debug unit. Uses round-robin arbitration with a valid/ready request handshake. Latches the winner's operands, drives them to the shared ALU for one cycle, then registers and holds the result on a valid/ready response channel tagged with the requester ID.

---
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Round-robin arbitration with valid/ready requests; the winner's operands are
// registered onto the ALU for one cycle, and the result is registered and held
// on a valid/ready response channel tagged with the requester id.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (port 0 always wins contention).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [OPW-1:0]   req0_ALUop,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [OPW-1:0]   req1_ALUop,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [OPW-1:0]   alu_ALUop,
  input  logic [WIDTH-1:0] alu_Out,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  input  logic             resp_ready
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic             grant_id_reg;
  logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
  logic [OPW-1:0]   alu_op_reg;
  logic             resp_valid_reg;
  logic             resp_id_reg;
  logic [WIDTH-1:0] resp_data_reg;

  // Requester ports gathered into arrays so per-port logic is generated.
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_a  [2];
  logic [WIDTH-1:0] req_b  [2];
  logic [OPW-1:0]   req_op [2];
  logic [1:0]       grant_vec;
  logic             winner;
  logic             accept;

  assign req_valid = {req1_valid, req0_valid};
  assign req_a[0]  = req0_A;
  assign req_a[1]  = req1_A;
  assign req_b[0]  = req0_B;
  assign req_b[1]  = req1_B;
  assign req_op[0] = req0_ALUop;
  assign req_op[1] = req1_ALUop;

  // Pick the winner: a lone valid port wins; on contention the port that was
  // not granted last wins (or port 0 always, in the fixed-priority build).
  always_comb begin
    winner = 1'b0;
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      winner = ~last_grant_reg;
`endif
    end else if (req_valid[1]) begin
      winner = 1'b1;
    end
  end

  // Ready is offered only in IDLE, never while reset is asserted, and only
  // to the winning port.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign grant_vec[gi] = (state_reg == IDLE) && !reset &&
                             req_valid[gi] && (winner == 1'(gi));
    end
  endgenerate

  assign req0_ready = grant_vec[0];
  assign req1_ready = grant_vec[1];
  assign accept     = |grant_vec;

  // Next-state logic: IDLE -> EXEC on handshake, EXEC -> HOLD always,
  // HOLD -> IDLE once the consumer takes the result.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = HOLD;
      HOLD:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, ALU operand latch, grant bookkeeping and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_id_reg   <= 1'b0;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_op_reg     <= '0;
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        alu_a_reg      <= req_a[winner];
        alu_b_reg      <= req_b[winner];
        alu_op_reg     <= req_op[winner];
        grant_id_reg   <= winner;
        last_grant_reg <= winner;
      end
      if (state_reg == EXEC) begin
        resp_data_reg  <= alu_Out;
        resp_id_reg    <= grant_id_reg;
        resp_valid_reg <= 1'b1;
      end
      if (state_reg == HOLD && resp_ready) begin
        resp_valid_reg <= 1'b0;
      end
    end
  end

  assign alu_A      = alu_a_reg;
  assign alu_B      = alu_b_reg;
  assign alu_ALUop  = alu_op_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_id    = resp_id_reg;
  assign resp_data  = resp_data_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level model of the arbiter.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_A, req0_B, req1_A, req1_B;
  logic [OPW-1:0]   req0_ALUop, req1_ALUop;
  logic [WIDTH-1:0] alu_A, alu_B, alu_Out;
  logic [OPW-1:0]   alu_ALUop;
  logic             resp_valid, resp_id, resp_ready;
  logic [WIDTH-1:0] resp_data;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Model state: which port was granted most recently.
  bit model_last = 1'b1;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // The shared combinational ALU lives in the environment.
  assign alu_Out = alu_ref(alu_ALUop, alu_A, alu_B);

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_ALUop(req0_ALUop),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_ALUop(req1_ALUop),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop), .alu_Out(alu_Out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  // Arbitration rule from the model's point of view.
  function automatic bit pick(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~model_last;
`endif
    end
    return v1;
  endfunction

  // One complete transaction: present requests, check the grant, follow the
  // result through EXEC/HOLD with bp cycles of backpressure, then release.
  task automatic run_txn(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic [3:0] op0,
                         input bit v1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic [3:0] op1, input int bp,
                         output bit got_id, output logic [31:0] got_data);
    bit w;
    logic [31:0] ea, ed;
    logic [3:0]  eop;
    req0_valid = v0; req0_A = a0; req0_B = b0; req0_ALUop = op0;
    req1_valid = v1; req1_A = a1; req1_B = b1; req1_ALUop = op1;
    resp_ready = 1'b0;
    #1;
    w   = pick(v0, v1);
    ea  = w ? a1 : a0;
    eop = w ? op1 : op0;
    ed  = alu_ref(eop, ea, w ? b1 : b0);
    chk("grant_ready0", {31'd0, req0_ready}, {31'd0, (w == 1'b0)});
    chk("grant_ready1", {31'd0, req1_ready}, {31'd0, (w == 1'b1)});
    step();
    model_last = w;
    if (w) req1_valid = 1'b0; else req0_valid = 1'b0;
    chk("exec_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("exec_alu_A", alu_A, ea);
    chk("exec_alu_op", {28'd0, alu_ALUop}, {28'd0, eop});
    chk("exec_resp_valid", {31'd0, resp_valid}, 32'd0);
    step();
    chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("hold_resp_id", {31'd0, resp_id}, {31'd0, w});
    chk("hold_resp_data", resp_data, ed);
    got_id   = resp_id;
    got_data = resp_data;
    for (int i = 0; i < bp; i++) begin
      step();
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_resp_data", resp_data, ed);
      chk("bp_resp_id", {31'd0, resp_id}, {31'd0, w});
      chk("bp_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    #1;
    chk("release_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    step();
    chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    resp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    txn++;
    $display("txn %0d: v0=%0d v1=%0d winner=%0d data=%h bp=%0d", txn, v0, v1, w, ed, bp);
  endtask

  initial begin
    bit          id;
    logic [31:0] data;
    bit          v0, v1;
    logic [31:0] ra0, rb0, ra1, rb1;
    logic [3:0]  rop0, rop1;

    reset = 1'b1;
    req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_ALUop = '0;
    req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_ALUop = '0;
    resp_ready = 1'b0;

    // Reset state, including readys suppressed while reset is high.
    step();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("reset_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    step();
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_resp_id", {31'd0, resp_id}, 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    chk("reset_alu_A", alu_A, 32'd0);
    chk("reset_alu_B", alu_B, 32'd0);
    chk("reset_alu_op", {28'd0, alu_ALUop}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
    model_last = 1'b1;
    #1;
    chk("idle_none_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    step();

    // Single ADD on port 0.
    run_txn(1'b1, 32'h5, 32'h3, OP_ADD, 1'b0, 32'h0, 32'h0, OP_ADD, 0, id, data);
    chk("add_data", data, 32'h8);
    chk("add_id", {31'd0, id}, 32'd0);

    // Contention from a fresh reset, with 5 cycles of backpressure on the first.
    do_reset();
    run_txn(1'b1, 32'h10, 32'h1, OP_SUB, 1'b1, 32'hF0F0F0F0, 32'hFFFF0000, OP_XOR, 5, id, data);
    chk("rr_first_id", {31'd0, id}, 32'd0);
    chk("rr_first_data", data, 32'h0000000F);
    run_txn(1'b1, 32'h10, 32'h1, OP_SUB, 1'b1, 32'hF0F0F0F0, 32'hFFFF0000, OP_XOR, 0, id, data);
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("rr_second_id", {31'd0, id}, 32'd0);
    chk("rr_second_data", data, 32'h0000000F);
    run_txn(1'b0, 32'h10, 32'h1, OP_SUB, 1'b1, 32'hF0F0F0F0, 32'hFFFF0000, OP_XOR, 0, id, data);
`endif
    chk("rr_req1_id", {31'd0, id}, 32'd1);
    chk("rr_req1_data", data, 32'h0F0FF0F0);

    // Signed comparison on port 1.
    run_txn(1'b0, 32'h0, 32'h0, OP_ADD, 1'b1, 32'h80000000, 32'h1, OP_SLT, 1, id, data);
    chk("slt_data", data, 32'h1);
    chk("slt_id", {31'd0, id}, 32'd1);

    // Reset during EXEC aborts the operation.
    req0_valid = 1'b1; req0_A = 32'h1234; req0_B = 32'h1; req0_ALUop = OP_ADD;
    req1_valid = 1'b1; req1_A = 32'h55;   req1_B = 32'h2; req1_ALUop = OP_SUB;
    step();
    reset = 1'b1;
    #1;
    chk("rst_exec_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
    step();
    chk("rst_exec_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_exec_alu_A", alu_A, 32'd0);
    reset = 1'b0;
    model_last = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk("rst_after_resp_valid", {31'd0, resp_valid}, 32'd0);
    run_txn(1'b1, 32'h7, 32'h9, OP_AND, 1'b1, 32'h3, 32'h4, OP_OR, 0, id, data);
    chk("rst_first_id", {31'd0, id}, 32'd0);

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      ra0 = $urandom; rb0 = $urandom; rop0 = 4'($urandom_range(0, 9));
      ra1 = $urandom; rb1 = $urandom; rop1 = 4'($urandom_range(0, 9));
      if (!v0 && !v1) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("rand_idle_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
        step();
        chk("rand_idle_resp_valid", {31'd0, resp_valid}, 32'd0);
      end else begin
        run_txn(v0, ra0, rb0, rop0, v1, ra1, rb1, rop1, $urandom_range(0, 3), id, data);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
